// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the write-back store buffer.
package store_buffer_pkg;

  localparam int SB_WORD_WIDTH = 32;
  localparam int SB_DEPTH      = 4;

  // One buffered store as seen at the memory side (word-aligned address).
  typedef struct packed {
    logic [SB_WORD_WIDTH-1:0] addr;
    logic [SB_WORD_WIDTH-1:0] data;
  } sb_entry_t;

  // Pointer and occupancy widths for a buffer of the given depth.
  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU data port and data-memory port of the store buffer, bundled.
// slave = the store buffer itself, master = cpu/memory environment.
interface store_buffer_if import store_buffer_pkg::*; #(
  parameter int W = SB_WORD_WIDTH
);
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         stall;
  logic [W-1:0] mem_rd_addr;
  logic [W-1:0] mem_rd_data;
  logic         mem_wr_en;
  logic [W-1:0] mem_wr_addr;
  logic [W-1:0] mem_wr_data;
  logic         mem_wr_ready;
  logic         empty;
  logic         full;

  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data, mem_rd_data, mem_wr_ready,
    output l_data, stall, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, empty, full
  );

  modport master (
    output load_en, l_addr, store_en, s_addr, s_data, mem_rd_data, mem_wr_ready,
    input  l_data, stall, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, empty, full
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// Load-forwarding lookup: per-entry validity + word-address compare,
// then youngest-match select walking from head towards tail.
module sb_fwd_match import store_buffer_pkg::*; #(
  parameter int W     = SB_WORD_WIDTH,
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = sb_ptr_w(DEPTH),
  parameter int CNT_W = sb_cnt_w(DEPTH)
) (
  input  logic [DEPTH-1:0][W-3:0] i_addr,    // stored word addresses
  input  logic [DEPTH-1:0][W-1:0] i_data,
  input  logic [PTR_W-1:0]        i_head,
  input  logic [CNT_W-1:0]        i_count,
  input  logic [W-3:0]            i_ld_addr, // load word address
  output logic                    o_hit,
  output logic [W-1:0]            o_data
);

  logic [DEPTH-1:0][PTR_W-1:0] w_age;
  logic [DEPTH-1:0]            w_match;

  // Slot age relative to head decides validity; pointers wrap naturally
  // because DEPTH is a power of two.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_age[g]   = PTR_W'(g) - i_head;
    assign w_match[g] = (CNT_W'(w_age[g]) < i_count) && (i_addr[g] == i_ld_addr);
  end

  // Scan oldest to youngest; the last match seen is the youngest store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head + PTR_W'(k);
      if (w_match[idx]) begin
        o_hit  = 1'b1;
        o_data = i_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: stores enter a DEPTH-entry FIFO in one cycle and
// drain to memory through a ready handshake; loads forward from the youngest
// matching buffered store, otherwise take memory read data.
module store_buffer import store_buffer_pkg::*; #(
  parameter int W     = SB_WORD_WIDTH,
  parameter int DEPTH = SB_DEPTH
) (
  input logic           clk,
  input logic           rst,   // async, active low
  store_buffer_if.slave bus
);

  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CNT_W = sb_cnt_w(DEPTH);

  logic [DEPTH-1:0][W-3:0] r_addr;
  logic [DEPTH-1:0][W-1:0] r_data;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;

  logic         w_full;
  logic         w_empty;
  logic         w_stall;
  logic         w_push;
  logic         w_pop;
  logic         w_hit;
  logic [W-1:0] w_fwd_data;
  logic         w_unused;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full is only a stall if memory is not freeing a slot this same edge.
  assign w_stall = bus.store_en & w_full & ~bus.mem_wr_ready;
  assign w_pop   = ~w_empty & bus.mem_wr_ready;
  assign w_push  = bus.store_en & ~w_stall;

  // Byte offsets are irrelevant for word-only accesses.
  assign w_unused = ^{bus.l_addr[1:0], bus.s_addr[1:0]};

  // Pointer and occupancy bookkeeping; reset discards all entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is not reset; only slots inside head..head+count-1 matter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.s_addr[W-1:2];
      r_data[r_tail] <= bus.s_data;
    end
  end

  sb_fwd_match #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_fwd (
    .i_addr    (r_addr),
    .i_data    (r_data),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_ld_addr (bus.l_addr[W-1:2]),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  // Forwarding uses pre-edge state, so a store pushed this cycle is not seen.
  assign bus.l_data      = (bus.load_en && w_hit) ? w_fwd_data : bus.mem_rd_data;
  assign bus.mem_rd_addr = {bus.l_addr[W-1:2], 2'b00};
  assign bus.mem_wr_en   = ~w_empty;
  assign bus.mem_wr_addr = {r_addr[r_head], 2'b00};
  assign bus.mem_wr_data = r_data[r_head];
  assign bus.stall       = w_stall;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;

endmodule
